rstation_append: RTL and testbench
==================================

# rstation_append

Reservation-station block of the Tomasulo core. It sits between the issue stage and the functional units. The issue stage presents one decoded instruction per cycle with its operand status; the block appends it to the add, multiply or branch station, captures CDB results for waiting operands, and dispatches ready entries to the matching functional unit. Each class has three entries.

## Interface
Parameters:
- ENTRIES, 3, entries per class station (counters sized for 0..3)
- DW, 16, operand data width
- TW, 3, ROB tag width (8-entry ROB)

Ports:
- clk1  in  1  clock; all state changes on posedge
- rst  in  1  reset; synchronous, active-high
- count  in  1  append request (issue valid) this cycle
- rs1b, rs2b  in  1 each  1 means operand pending on ROB tag, 0 means value valid
- rs1, rs2  in  4 each  source register indices (kept for debug readout only)
- rs1_data, rs2_data  in  DW each  operand value when ready; when pending, bits [TW-1:0] carry the ROB tag
- rob_ind  in  TW  destination ROB tag of the instruction
- func  in  4  opcode (0000/0001 add class, 0010/0011 mul class, 01xx branch class, 1xxx illegal)
- rd  in  4  destination register
- cdb_valid  in  1, cdb_tag  in  TW, cdb_data  in  DW  common data bus broadcast
- add_rdy, mul_rdy, bch_rdy  in  1 each  functional unit accepts a dispatch this cycle
- stall  out  1  append refused because the target station is full
- illegal  out  1  append refused because func is 1xxx
- add_count, mul_count, bch_count  out  2 each  occupied entries per station
- {add,mul,bch}_dv  out  1  dispatch valid
- {add,mul,bch}_func  out  4, _vj/_vk  out  DW, _rob  out  TW, _rd  out  4  dispatched entry fields

## Operation
- Entry fields: busy, func, rd, rob, Vj, Vk, Qj, Qk, rj, rk. The rj/rk bits mean the operand is ready.
- Append: when count=1 and func is legal, class is chosen from func. If the station has a free entry, the lowest-index free entry (based on pre-edge state) is written with busy=1.
  - Operand j: if rs1b=0, Vj=rs1_data and rj=1. If rs1b=1, Qj=rs1_data[TW-1:0] and rj=0. Operand k is handled the same way.
  - Same-cycle bypass: if a pending operand's tag equals cdb_tag while cdb_valid=1, the entry captures cdb_data with ready=1.
- stall = count & legal & station full (combinational). illegal = count & func[3] (combinational). A refused request writes nothing; the issue stage holds the instruction.
- Wakeup: every cycle, each busy entry whose pending Qj/Qk equals cdb_tag (cdb_valid=1) captures cdb_data and sets rj/rk. Both operands may wake in the same cycle.
- Dispatch per station (combinational select): x_dv=1 when some busy entry has rj&rk. The lowest-index such entry drives the x_func/x_vj/x_vk/x_rob/x_rd outputs.
  - If x_rdy=1 at the edge, that entry is cleared (busy=0).
  - Outputs are don't-care when x_dv=0; drive 0.
- Counts are registered: next = current + append − dispatch, per station.
- Operands woken this cycle are not dispatchable until the next cycle; select uses registered state.

## Timing
- Reset: all busy=0, all counts 0. With no busy entries, stall/illegal/x_dv are 0 and all dispatch fields are 0. Reset overrides a simultaneous append, wakeup and dispatch.
- Append latency: entry is visible (count incremented) one cycle after the request edge. Earliest dispatch is that cycle if both operands are ready.
- Dispatch handshake: x_dv && x_rdy at posedge frees the entry. If x_rdy=0, the entry stays and the outputs hold.
- Full station with simultaneous dispatch: stall is still asserted. A freed slot is not reusable in the same cycle, and the count decrements.
- Append + dispatch in the same station and cycle: count is unchanged; the new entry goes in a different slot.
- Counts never exceed 3 and never underflow.

## Test plan
- Reset, then append func=0000, rs1b=0, rs1_data=5, rs2b=0, rs2_data=7, rob_ind=2, rd=4, with add_rdy=0 → next cycle add_count=1, add_dv=1, add_vj=5, add_vk=7, add_rob=2, add_rd=4. Then add_rdy=1 for one cycle → add_count=0, add_dv=0.
- Four mul appends (func=0010, add/mul rdy=0) → mul_count=3. The fourth request sees stall=1 and mul_count stays 3. add_count and bch_count stay 0.
- Append func=0011 with rs1b=1, rs1_data=3 (tag 3) → mul_dv=0. Then cdb_valid=1, cdb_tag=3, cdb_data=0x00AA → next cycle mul_dv=1, mul_vj=0x00AA.
- Append with rs2b=1, tag 6, while cdb_valid=1, cdb_tag=6, cdb_data=9 in the same cycle → next cycle dispatchable with vk=9.
- func=1000 with count=1 → illegal=1, no station count changes. func=0101 → bch_count=1.
- Full add station, add_rdy=1 and a new add append in the same cycle → stall=1, and add_count drops 3→2.

Source files
------------

// File: rtl/rstation_append_if.sv
// Issue, CDB and dispatch bundle of the reservation-station block.
// The issue/CDB/FU side drives through master; the stations sit on slave.
interface rstation_append_if #(
    parameter int ENTRIES = 3,
    parameter int DW      = 16,
    parameter int TW      = 3
);
    localparam int CW = $clog2(ENTRIES + 1);

    logic          count;
    logic          rs1b;
    logic          rs2b;
    logic [3:0]    rs1;
    logic [3:0]    rs2;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [TW-1:0] rob_ind;
    logic [3:0]    func;
    logic [3:0]    rd;

    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;

    logic          add_rdy;
    logic          mul_rdy;
    logic          bch_rdy;

    logic          stall;
    logic          illegal;
    logic [CW-1:0] add_count;
    logic [CW-1:0] mul_count;
    logic [CW-1:0] bch_count;

    logic          add_dv;
    logic [3:0]    add_func;
    logic [DW-1:0] add_vj;
    logic [DW-1:0] add_vk;
    logic [TW-1:0] add_rob;
    logic [3:0]    add_rd;

    logic          mul_dv;
    logic [3:0]    mul_func;
    logic [DW-1:0] mul_vj;
    logic [DW-1:0] mul_vk;
    logic [TW-1:0] mul_rob;
    logic [3:0]    mul_rd;

    logic          bch_dv;
    logic [3:0]    bch_func;
    logic [DW-1:0] bch_vj;
    logic [DW-1:0] bch_vk;
    logic [TW-1:0] bch_rob;
    logic [3:0]    bch_rd;

    modport master (
        output count, rs1b, rs2b, rs1, rs2, rs1_data, rs2_data, rob_ind, func, rd,
        output cdb_valid, cdb_tag, cdb_data,
        output add_rdy, mul_rdy, bch_rdy,
        input  stall, illegal, add_count, mul_count, bch_count,
        input  add_dv, add_func, add_vj, add_vk, add_rob, add_rd,
        input  mul_dv, mul_func, mul_vj, mul_vk, mul_rob, mul_rd,
        input  bch_dv, bch_func, bch_vj, bch_vk, bch_rob, bch_rd
    );

    modport slave (
        input  count, rs1b, rs2b, rs1, rs2, rs1_data, rs2_data, rob_ind, func, rd,
        input  cdb_valid, cdb_tag, cdb_data,
        input  add_rdy, mul_rdy, bch_rdy,
        output stall, illegal, add_count, mul_count, bch_count,
        output add_dv, add_func, add_vj, add_vk, add_rob, add_rd,
        output mul_dv, mul_func, mul_vj, mul_vk, mul_rob, mul_rd,
        output bch_dv, bch_func, bch_vj, bch_vk, bch_rob, bch_rd
    );
endinterface

// File: rtl/rstation_append.sv
// Add/mul/branch reservation stations: append from issue, CDB wakeup,
// and lowest-index-ready dispatch to each functional unit.
module rstation_append #(
    parameter int ENTRIES = 3,
    parameter int DW      = 16,
    parameter int TW      = 3
) (
    input logic clk1,
    input logic rst,
    rstation_append_if.slave bus
);
    localparam int NCLS = 3;
    localparam int IW   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW   = $clog2(ENTRIES + 1);

    // Class index: 0 add, 1 mul, 2 branch. Illegal opcodes are gated separately.
    function automatic logic [1:0] class_of(input logic [3:0] f);
        if (f[2])      return 2'd2;
        else if (f[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    logic          busy   [NCLS][ENTRIES];
    logic [3:0]    e_func [NCLS][ENTRIES];
    logic [3:0]    e_rd   [NCLS][ENTRIES];
    logic [TW-1:0] e_rob  [NCLS][ENTRIES];
    logic [TW-1:0] e_qj   [NCLS][ENTRIES];
    logic [TW-1:0] e_qk   [NCLS][ENTRIES];
    logic [DW-1:0] e_vj   [NCLS][ENTRIES];
    logic [DW-1:0] e_vk   [NCLS][ENTRIES];
    logic          e_rj   [NCLS][ENTRIES];
    logic          e_rk   [NCLS][ENTRIES];
    logic [CW-1:0] cnt    [NCLS];

    logic [1:0]    req_cls;
    logic          legal_req;
    logic          stall_c;
    logic          full     [NCLS];
    logic [IW-1:0] free_idx [NCLS];
    logic          app      [NCLS];
    logic          dv       [NCLS];
    logic [IW-1:0] sel      [NCLS];
    logic          rdy      [NCLS];
    logic          fire     [NCLS];

    // Source register numbers are carried for debug visibility only.
    logic unused_debug;
    assign unused_debug = ^{bus.rs1, bus.rs2};

    always_comb begin
        req_cls   = class_of(bus.func);
        legal_req = bus.count & ~bus.func[3];
        stall_c   = 1'b0;
        rdy[0]    = bus.add_rdy;
        rdy[1]    = bus.mul_rdy;
        rdy[2]    = bus.bch_rdy;
        for (int c = 0; c < NCLS; c++) begin
            full[c]     = 1'b1;
            free_idx[c] = '0;
            dv[c]       = 1'b0;
            sel[c]      = '0;
            // Scanning downward leaves the lowest matching index selected.
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (!busy[c][i]) begin
                    full[c]     = 1'b0;
                    free_idx[c] = IW'(i);
                end
                if (busy[c][i] && e_rj[c][i] && e_rk[c][i]) begin
                    dv[c]  = 1'b1;
                    sel[c] = IW'(i);
                end
            end
            app[c]  = legal_req && (req_cls == 2'(c)) && !full[c];
            fire[c] = dv[c] && rdy[c];
            stall_c = stall_c | (legal_req && (req_cls == 2'(c)) && full[c]);
        end
    end

    assign bus.stall   = stall_c;
    assign bus.illegal = bus.count & bus.func[3];

    // Occupancy and busy bits: the only state that reset touches.
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int c = 0; c < NCLS; c++) begin
                cnt[c] <= '0;
                for (int i = 0; i < ENTRIES; i++) busy[c][i] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NCLS; c++) begin
                cnt[c] <= cnt[c] + CW'(app[c]) - CW'(fire[c]);
                for (int i = 0; i < ENTRIES; i++) begin
                    if (fire[c] && sel[c] == IW'(i)) busy[c][i] <= 1'b0;
                    if (app[c] && free_idx[c] == IW'(i)) busy[c][i] <= 1'b1;
                end
            end
        end
    end

    // Entry payload: wakeup on busy entries, then append into the free slot.
    always_ff @(posedge clk1) begin
        for (int c = 0; c < NCLS; c++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy[c][i] && !e_rj[c][i] && bus.cdb_valid && e_qj[c][i] == bus.cdb_tag) begin
                    e_vj[c][i] <= bus.cdb_data;
                    e_rj[c][i] <= 1'b1;
                end
                if (busy[c][i] && !e_rk[c][i] && bus.cdb_valid && e_qk[c][i] == bus.cdb_tag) begin
                    e_vk[c][i] <= bus.cdb_data;
                    e_rk[c][i] <= 1'b1;
                end
                if (app[c] && free_idx[c] == IW'(i)) begin
                    e_func[c][i] <= bus.func;
                    e_rd[c][i]   <= bus.rd;
                    e_rob[c][i]  <= bus.rob_ind;
                    e_qj[c][i]   <= bus.rs1_data[TW-1:0];
                    e_qk[c][i]   <= bus.rs2_data[TW-1:0];
                    if (!bus.rs1b) begin
                        e_vj[c][i] <= bus.rs1_data;
                        e_rj[c][i] <= 1'b1;
                    end else if (bus.cdb_valid && bus.cdb_tag == bus.rs1_data[TW-1:0]) begin
                        e_vj[c][i] <= bus.cdb_data;
                        e_rj[c][i] <= 1'b1;
                    end else begin
                        e_rj[c][i] <= 1'b0;
                    end
                    if (!bus.rs2b) begin
                        e_vk[c][i] <= bus.rs2_data;
                        e_rk[c][i] <= 1'b1;
                    end else if (bus.cdb_valid && bus.cdb_tag == bus.rs2_data[TW-1:0]) begin
                        e_vk[c][i] <= bus.cdb_data;
                        e_rk[c][i] <= 1'b1;
                    end else begin
                        e_rk[c][i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.add_count = cnt[0];
    assign bus.mul_count = cnt[1];
    assign bus.bch_count = cnt[2];

    assign bus.add_dv   = dv[0];
    assign bus.add_func = dv[0] ? e_func[0][sel[0]] : '0;
    assign bus.add_vj   = dv[0] ? e_vj[0][sel[0]]   : '0;
    assign bus.add_vk   = dv[0] ? e_vk[0][sel[0]]   : '0;
    assign bus.add_rob  = dv[0] ? e_rob[0][sel[0]]  : '0;
    assign bus.add_rd   = dv[0] ? e_rd[0][sel[0]]   : '0;

    assign bus.mul_dv   = dv[1];
    assign bus.mul_func = dv[1] ? e_func[1][sel[1]] : '0;
    assign bus.mul_vj   = dv[1] ? e_vj[1][sel[1]]   : '0;
    assign bus.mul_vk   = dv[1] ? e_vk[1][sel[1]]   : '0;
    assign bus.mul_rob  = dv[1] ? e_rob[1][sel[1]]  : '0;
    assign bus.mul_rd   = dv[1] ? e_rd[1][sel[1]]   : '0;

    assign bus.bch_dv   = dv[2];
    assign bus.bch_func = dv[2] ? e_func[2][sel[2]] : '0;
    assign bus.bch_vj   = dv[2] ? e_vj[2][sel[2]]   : '0;
    assign bus.bch_vk   = dv[2] ? e_vk[2][sel[2]]   : '0;
    assign bus.bch_rob  = dv[2] ? e_rob[2][sel[2]]  : '0;
    assign bus.bch_rd   = dv[2] ? e_rd[2][sel[2]]   : '0;
endmodule

// File: tb/tb_rstation_append.sv
// Bench for rstation_append: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a slot-level model.
module tb_rstation_append;
    localparam int ENTRIES = 3;
    localparam int DW      = 16;
    localparam int TW      = 3;

    logic clk1 = 1'b0;
    logic rst;
    always #5 clk1 = ~clk1;

    rstation_append_if #(.ENTRIES(ENTRIES), .DW(DW), .TW(TW)) bus ();

    rstation_append #(.ENTRIES(ENTRIES), .DW(DW), .TW(TW)) dut (
        .clk1(clk1),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        busy;
        bit [3:0]  func;
        bit [3:0]  rd;
        bit [2:0]  rob;
        bit [2:0]  qj;
        bit [2:0]  qk;
        bit [15:0] vj;
        bit [15:0] vk;
        bit        rj;
        bit        rk;
    } ent_t;

    ent_t m [3][3];
    bit   model_ok = 1'b0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int cls_of(input bit [3:0] f);
        if (f[3]) return -1;
        if (f[2]) return 2;
        if (f[1]) return 1;
        return 0;
    endfunction

    function automatic int occ(input int c);
        int n = 0;
        for (int i = 0; i < 3; i++) if (m[c][i].busy) n++;
        return n;
    endfunction

    function automatic int pick(input int c);
        for (int i = 0; i < 3; i++) if (m[c][i].busy && m[c][i].rj && m[c][i].rk) return i;
        return -1;
    endfunction

    function automatic int free_of(input int c);
        for (int i = 0; i < 3; i++) if (!m[c][i].busy) return i;
        return -1;
    endfunction

    function automatic bit rdy_of(input int c);
        return (c == 0) ? bus.add_rdy : (c == 1) ? bus.mul_rdy : bus.bch_rdy;
    endfunction

    task automatic chk_disp(input string nm, input int c, input logic dv, input logic [3:0] fn,
                            input logic [15:0] vj, input logic [15:0] vk,
                            input logic [2:0] rob, input logic [3:0] rd);
        int s = pick(c);
        chk({nm, "_dv"}, 32'(dv), 32'(s >= 0));
        chk({nm, "_func"}, 32'(fn),  s >= 0 ? 32'(m[c][s].func) : 0);
        chk({nm, "_vj"},   32'(vj),  s >= 0 ? 32'(m[c][s].vj)   : 0);
        chk({nm, "_vk"},   32'(vk),  s >= 0 ? 32'(m[c][s].vk)   : 0);
        chk({nm, "_rob"},  32'(rob), s >= 0 ? 32'(m[c][s].rob)  : 0);
        chk({nm, "_rd"},   32'(rd),  s >= 0 ? 32'(m[c][s].rd)   : 0);
    endtask

    task automatic compare_all();
        int rc = bus.count ? cls_of(bus.func) : -1;
        chk("stall",   32'(bus.stall),   32'(rc >= 0 && occ(rc) == 3));
        chk("illegal", 32'(bus.illegal), 32'(bus.count && bus.func[3]));
        chk("add_count", 32'(bus.add_count), 32'(occ(0)));
        chk("mul_count", 32'(bus.mul_count), 32'(occ(1)));
        chk("bch_count", 32'(bus.bch_count), 32'(occ(2)));
        chk_disp("add", 0, bus.add_dv, bus.add_func, bus.add_vj, bus.add_vk, bus.add_rob, bus.add_rd);
        chk_disp("mul", 1, bus.mul_dv, bus.mul_func, bus.mul_vj, bus.mul_vk, bus.mul_rob, bus.mul_rd);
        chk_disp("bch", 2, bus.bch_dv, bus.bch_func, bus.bch_vj, bus.bch_vk, bus.bch_rob, bus.bch_rd);
    endtask

    // Next-state of the stations from the rules, using the inputs of this cycle.
    task automatic model_step();
        int rc;
        if (rst) begin
            for (int c = 0; c < 3; c++) for (int i = 0; i < 3; i++) m[c][i].busy = 1'b0;
            model_ok = 1'b1;
            return;
        end
        rc = bus.count ? cls_of(bus.func) : -1;
        for (int c = 0; c < 3; c++) begin
            int s = pick(c);
            int f = free_of(c);
            int o = occ(c);
            for (int i = 0; i < 3; i++) begin
                if (m[c][i].busy && bus.cdb_valid) begin
                    if (!m[c][i].rj && m[c][i].qj == bus.cdb_tag) begin m[c][i].vj = bus.cdb_data; m[c][i].rj = 1; end
                    if (!m[c][i].rk && m[c][i].qk == bus.cdb_tag) begin m[c][i].vk = bus.cdb_data; m[c][i].rk = 1; end
                end
            end
            if (s >= 0 && rdy_of(c)) m[c][s].busy = 1'b0;
            if (rc == c && o < 3) begin
                ent_t e;
                e.busy = 1; e.func = bus.func; e.rd = bus.rd; e.rob = bus.rob_ind;
                e.qj = bus.rs1_data[2:0]; e.qk = bus.rs2_data[2:0];
                e.vj = bus.rs1_data; e.rj = 1;
                e.vk = bus.rs2_data; e.rk = 1;
                if (bus.rs1b) begin
                    e.rj = bus.cdb_valid && bus.cdb_tag == e.qj;
                    e.vj = e.rj ? bus.cdb_data : 16'h0;
                end
                if (bus.rs2b) begin
                    e.rk = bus.cdb_valid && bus.cdb_tag == e.qk;
                    e.vk = e.rk ? bus.cdb_data : 16'h0;
                end
                m[c][f] = e;
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk1);
        if (model_ok) compare_all();
        model_step();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        bus.count = 0; bus.func = 0; bus.rd = 0; bus.rob_ind = 0;
        bus.rs1b = 0; bus.rs2b = 0; bus.rs1 = 0; bus.rs2 = 0;
        bus.rs1_data = 0; bus.rs2_data = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.add_rdy = 0; bus.mul_rdy = 0; bus.bch_rdy = 0;
    endtask

    task automatic issue(input logic [3:0] f, input logic b1, input logic [15:0] d1,
                         input logic b2, input logic [15:0] d2, input logic [2:0] rob, input logic [3:0] rd);
        bus.count = 1; bus.func = f; bus.rs1b = b1; bus.rs1_data = d1;
        bus.rs2b = b2; bus.rs2_data = d2; bus.rob_ind = rob; bus.rd = rd;
    endtask

    initial begin
        idle();
        rst = 1;
        run_cycle();
        run_cycle();
        rst = 0;
        #1;
        chk("rst_add_count", 32'(bus.add_count), 0);
        chk("rst_add_dv", 32'(bus.add_dv), 0);
        chk("rst_stall", 32'(bus.stall), 0);

        // Simple add append, held while add unit busy, then dispatched.
        issue(4'b0000, 0, 16'd5, 0, 16'd7, 3'd2, 4'd4);
        run_cycle();
        idle();
        #1;
        chk("t1_add_count", 32'(bus.add_count), 1);
        chk("t1_add_dv", 32'(bus.add_dv), 1);
        chk("t1_add_vj", 32'(bus.add_vj), 5);
        chk("t1_add_vk", 32'(bus.add_vk), 7);
        chk("t1_add_rob", 32'(bus.add_rob), 2);
        chk("t1_add_rd", 32'(bus.add_rd), 4);
        bus.add_rdy = 1;
        run_cycle();
        idle();
        #1;
        chk("t1_drain_count", 32'(bus.add_count), 0);
        chk("t1_drain_dv", 32'(bus.add_dv), 0);

        // Four mul appends: the fourth is refused.
        for (int k = 0; k < 4; k++) begin
            issue(4'b0010, 0, 16'(k + 1), 0, 16'(k + 10), 3'(k), 4'(k));
            #1;
            if (k == 3) chk("t2_stall", 32'(bus.stall), 1);
            run_cycle();
        end
        idle();
        #1;
        chk("t2_mul_count", 32'(bus.mul_count), 3);
        chk("t2_add_count", 32'(bus.add_count), 0);
        chk("t2_bch_count", 32'(bus.bch_count), 0);
        chk("t2_mul_vj_lowest", 32'(bus.mul_vj), 1);
        bus.mul_rdy = 1;
        repeat (3) run_cycle();
        idle();

        // Pending operand woken by a later CDB broadcast.
        issue(4'b0011, 1, 16'd3, 0, 16'd1, 3'd5, 4'd9);
        run_cycle();
        idle();
        #1;
        chk("t3_mul_dv_wait", 32'(bus.mul_dv), 0);
        bus.cdb_valid = 1; bus.cdb_tag = 3; bus.cdb_data = 16'h00AA;
        run_cycle();
        idle();
        #1;
        chk("t3_mul_dv", 32'(bus.mul_dv), 1);
        chk("t3_mul_vj", 32'(bus.mul_vj), 32'h00AA);
        bus.mul_rdy = 1;
        run_cycle();
        idle();

        // Same-cycle CDB bypass into the appended entry.
        issue(4'b0001, 0, 16'd2, 1, 16'd6, 3'd1, 4'd3);
        bus.cdb_valid = 1; bus.cdb_tag = 6; bus.cdb_data = 16'd9;
        run_cycle();
        idle();
        #1;
        chk("t4_add_dv", 32'(bus.add_dv), 1);
        chk("t4_add_vk", 32'(bus.add_vk), 9);
        bus.add_rdy = 1;
        run_cycle();
        idle();

        // Illegal opcode, then a branch append.
        issue(4'b1000, 0, 16'd1, 0, 16'd1, 3'd0, 4'd0);
        #1;
        chk("t5_illegal", 32'(bus.illegal), 1);
        chk("t5_stall", 32'(bus.stall), 0);
        run_cycle();
        idle();
        #1;
        chk("t5_counts", 32'({bus.add_count, bus.mul_count, bus.bch_count}), 0);
        issue(4'b0101, 0, 16'd4, 0, 16'd4, 3'd7, 4'd1);
        run_cycle();
        idle();
        #1;
        chk("t5_bch_count", 32'(bus.bch_count), 1);
        bus.bch_rdy = 1;
        run_cycle();
        idle();

        // Full add station with dispatch and append in the same cycle.
        for (int k = 0; k < 3; k++) begin
            issue(4'b0000, 0, 16'(k), 0, 16'(k), 3'(k), 4'(k));
            run_cycle();
        end
        issue(4'b0001, 0, 16'd50, 0, 16'd51, 3'd4, 4'd4);
        bus.add_rdy = 1;
        #1;
        chk("t6_stall", 32'(bus.stall), 1);
        run_cycle();
        idle();
        #1;
        chk("t6_add_count", 32'(bus.add_count), 2);
        bus.add_rdy = 1;
        repeat (2) run_cycle();
        idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.count     = ($urandom_range(0, 3) != 0);
            bus.func      = 4'($urandom);
            bus.rs1b      = 1'($urandom);
            bus.rs2b      = 1'($urandom);
            bus.rs1       = 4'($urandom);
            bus.rs2       = 4'($urandom);
            bus.rs1_data  = 16'($urandom);
            bus.rs2_data  = 16'($urandom);
            bus.rob_ind   = 3'($urandom);
            bus.rd        = 4'($urandom);
            bus.cdb_valid = 1'($urandom);
            bus.cdb_tag   = 3'($urandom);
            bus.cdb_data  = 16'($urandom);
            bus.add_rdy   = ($urandom_range(0, 2) == 0);
            bus.mul_rdy   = ($urandom_range(0, 2) == 0);
            bus.bch_rdy   = ($urandom_range(0, 2) == 0);
            run_cycle();
        end
        rst = 0;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
